// File: rtl/lv_pwm_dt_mon.sv
// lv_pwm_dt_mon: synchronises the half-bridge PWM pins, checks dead time and shoot-through,
// and gates the drives off on any violation. Rev 1.0
`default_nettype none

module lv_pwm_dt_mon #(
  parameter int MM_FILT  = 2,
  parameter int SYNC_STG = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pwm_h,
  input  logic       i_pwm_l,
  input  logic       i_pwm_ctrl,
  input  logic [7:0] i_dt_min,
  input  logic       i_err_clr,
  output logic       o_pwm_h,
  output logic       o_pwm_l,
  output logic       o_lv_pwm_dt_err,
  output logic       o_lv_pwm_mm_err
);

  logic [SYNC_STG-1:0] sync_h;
  logic [SYNC_STG-1:0] sync_l;
  logic                ph;
  logic                pl;
  logic [7:0]          dt_cnt;
  logic [3:0]          mm_cnt;

  logic       sh;
  logic       sl;
  logic       rise_h;
  logic       rise_l;
  logic       dt_hit;
  logic       mm_hit;
  logic [3:0] mm_next;
  logic       gate_en;

  assign sh     = sync_h[SYNC_STG-1];
  assign sl     = sync_l[SYNC_STG-1];
  assign rise_h = sh & ~ph;
  assign rise_l = sl & ~pl;

  // A simultaneous rise has the other pin high, so it is left to the mismatch filter.
  always_comb begin
    dt_hit  = ((rise_h & ~sl) | (rise_l & ~sh)) & (dt_cnt < i_dt_min) &
              (i_dt_min != 8'd0) & i_pwm_ctrl;
    mm_next = 4'd0;
    if (sh & sl & i_pwm_ctrl) begin
      mm_next = (mm_cnt == 4'hF) ? mm_cnt : mm_cnt + 4'd1;
    end
    mm_hit  = (mm_next == 4'(MM_FILT));
    gate_en = i_pwm_ctrl & ~o_lv_pwm_dt_err & ~o_lv_pwm_mm_err & ~dt_hit & ~(sh & sl);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_h <= '0;
      sync_l <= '0;
      ph     <= 1'b0;
      pl     <= 1'b0;
    end else begin
      sync_h <= (sync_h << 1) | SYNC_STG'(i_pwm_h);
      sync_l <= (sync_l << 1) | SYNC_STG'(i_pwm_l);
      ph     <= sh;
      pl     <= sl;
    end
  end

  // dt_cnt resets to full scale so the first edge after reset is never flagged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dt_cnt <= 8'hFF;
      mm_cnt <= 4'd0;
    end else begin
      if (sh | sl) begin
        dt_cnt <= 8'd0;
      end else if (dt_cnt != 8'hFF) begin
        dt_cnt <= dt_cnt + 8'd1;
      end
      mm_cnt <= mm_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pwm_h         <= 1'b0;
      o_pwm_l         <= 1'b0;
      o_lv_pwm_dt_err <= 1'b0;
      o_lv_pwm_mm_err <= 1'b0;
    end else begin
      o_pwm_h         <= sh & gate_en;
      o_pwm_l         <= sl & gate_en;
      o_lv_pwm_dt_err <= dt_hit | (o_lv_pwm_dt_err & ~i_err_clr);
      o_lv_pwm_mm_err <= mm_hit | (o_lv_pwm_mm_err & ~i_err_clr);
    end
  end

endmodule

`default_nettype wire
